// File: rtl/reg8_bank.sv
// reg8_bank: 8 x 16-bit register bank feeding Mux8Way16 (q_a..q_h -> a..h, rd_sel -> sel).
// Valid/ready write port, per-word written flags and an 8-cycle sequenced clear engine.
// Optional feature macro: REG8_BYTE_WRITE_EN adds the wr_be byte-enable port.
module reg8_bank #(
    parameter logic [15:0] INIT_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
`ifdef REG8_BYTE_WRITE_EN
    input  logic [1:0]  wr_be,
`endif
    input  logic        clr_req,
    output logic        busy,
    input  logic [2:0]  rd_addr,
    output logic [2:0]  rd_sel,
    output logic [15:0] q_a,
    output logic [15:0] q_b,
    output logic [15:0] q_c,
    output logic [15:0] q_d,
    output logic [15:0] q_e,
    output logic [15:0] q_f,
    output logic [15:0] q_g,
    output logic [15:0] q_h,
    output logic [7:0]  written
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  clr_cnt;
    logic [15:0] mem [8];
    logic        accept;

    // Next-state and handshake decode; writes are only taken outside a clear.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) state_next = CLEAR;
            end
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == 3'd7) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        wr_ready = !busy;
    end

    assign accept = wr_valid && wr_ready;

    // State register and clear counter; the counter idles at zero so each clear starts at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_cnt <= clr_cnt + 3'd1;
            else                clr_cnt <= '0;
        end
    end

    // Word storage and written flags: clear engine one word per cycle, otherwise accepted writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem     <= '{default: INIT_VALUE};
            written <= '0;
        end else if (state == CLEAR) begin
            mem[clr_cnt]     <= INIT_VALUE;
            written[clr_cnt] <= 1'b0;
        end else if (accept) begin
`ifdef REG8_BYTE_WRITE_EN
            if (wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
            if (wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
            if (wr_be != 2'b00) written[wr_addr] <= 1'b1;
`else
            mem[wr_addr]     <= wr_data;
            written[wr_addr] <= 1'b1;
`endif
        end
    end

    // Read select register: one-cycle latency into the downstream mux, active during clears too.
    always_ff @(posedge clk) begin
        if (reset) rd_sel <= '0;
        else       rd_sel <= rd_addr;
    end

    assign q_a = mem[0];
    assign q_b = mem[1];
    assign q_c = mem[2];
    assign q_d = mem[3];
    assign q_e = mem[4];
    assign q_f = mem[5];
    assign q_g = mem[6];
    assign q_h = mem[7];

endmodule
